// File: rtl/signed_minmax_tracker_if.sv
// Stream bundle for the signed min/max tracker: operand input channel,
// packet result channel and the abort strobe.
interface signed_minmax_tracker_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             abort;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_min;
    logic [WIDTH-1:0] out_max;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_data, in_last, abort, out_ready,
        input  in_ready, out_valid, out_min, out_max, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, abort, out_ready,
        output in_ready, out_valid, out_min, out_max, out_count
    );
endinterface

// File: rtl/signed_minmax_tracker.sv
// Per-packet signed min/max/count tracker using SLT-style compares
// (subtract, then sign XOR overflow).
module signed_minmax_tracker #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input logic                     clk,
    input logic                     rst_n,
    signed_minmax_tracker_if.slave  bus
);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    logic             out_valid;
    logic [WIDTH-1:0] min_q;
    logic [WIDTH-1:0] max_q;
    logic [CNT_W-1:0] count_q;
    logic             accept;
    logic             lt_min;
    logic             lt_max;

    function automatic logic slt(input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] diff;
        logic             v;
        diff = a + ~b + WIDTH'(1);
        v    = (a[MSB] == ~b[MSB]) && (a[MSB] != diff[MSB]);
        return diff[MSB] ^ v;
    endfunction

    // Ready is gated by rst_n so the input stalls while reset is held.
    assign bus.in_ready  = rst_n && (state != HOLD);
    assign bus.out_valid = out_valid;
    assign bus.out_min   = min_q;
    assign bus.out_max   = max_q;
    assign bus.out_count = count_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign lt_min = slt(bus.in_data, min_q);
    assign lt_max = slt(max_q, bus.in_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            min_q     <= '0;
            max_q     <= '0;
            count_q   <= '0;
        end else if (bus.abort) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        min_q   <= bus.in_data;
                        max_q   <= bus.in_data;
                        count_q <= CNT_W'(1);
                        if (bus.in_last) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (lt_min) min_q <= bus.in_data;
                        if (lt_max) max_q <= bus.in_data;
                        if (count_q != '1) count_q <= count_q + CNT_W'(1);
                        if (bus.in_last) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_signed_minmax_tracker.sv
// Bench for signed_minmax_tracker: directed packets plus random traffic,
// two instances (16-bit and 4-bit counters) fed the same stream.
module tb_signed_minmax_tracker;
    logic clk;
    logic rst_n;

    signed_minmax_tracker_if #(.WIDTH(32), .CNT_W(16)) bus ();
    signed_minmax_tracker_if #(.WIDTH(32), .CNT_W(4))  bus4 ();

    signed_minmax_tracker #(.WIDTH(32), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    signed_minmax_tracker #(.WIDTH(32), .CNT_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    assign bus4.in_valid  = bus.in_valid;
    assign bus4.in_data   = bus.in_data;
    assign bus4.in_last   = bus.in_last;
    assign bus4.abort     = bus.abort;
    assign bus4.out_ready = bus.out_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    // Reference: beats of the packet in progress and the last completed result.
    logic [31:0] beats[$];
    bit          holding;
    logic [31:0] exp_min;
    logic [31:0] exp_max;
    int          exp_cnt;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic close_packet();
        exp_min = beats[0];
        exp_max = beats[0];
        foreach (beats[i]) begin
            if ($signed(beats[i]) < $signed(exp_min)) exp_min = beats[i];
            if ($signed(beats[i]) > $signed(exp_max)) exp_max = beats[i];
        end
        exp_cnt = beats.size();
        beats.delete();
        holding = 1'b1;
    endtask

    task automatic model_edge(input bit v, input logic [31:0] d, input bit l,
                              input bit ab, input bit ordy);
        if (ab) begin
            beats.delete();
            holding = 1'b0;
        end else if (holding) begin
            if (ordy) holding = 1'b0;
        end else if (v) begin
            beats.push_back(d);
            if (l) close_packet();
        end
    endtask

    task automatic compare();
        int sat16;
        int sat4;
        sat16 = (exp_cnt > 65535) ? 65535 : exp_cnt;
        sat4  = (exp_cnt > 15) ? 15 : exp_cnt;
        check("in_ready", {63'd0, bus.in_ready}, {63'd0, !holding});
        check("out_valid", {63'd0, bus.out_valid}, {63'd0, holding});
        check("in_ready4", {63'd0, bus4.in_ready}, {63'd0, !holding});
        check("out_valid4", {63'd0, bus4.out_valid}, {63'd0, holding});
        if (holding) begin
            check("out_min", {32'd0, bus.out_min}, {32'd0, exp_min});
            check("out_max", {32'd0, bus.out_max}, {32'd0, exp_max});
            check("out_count", {48'd0, bus.out_count}, 64'(sat16));
            check("out_min4", {32'd0, bus4.out_min}, {32'd0, exp_min});
            check("out_max4", {32'd0, bus4.out_max}, {32'd0, exp_max});
            check("out_count4", {60'd0, bus4.out_count}, 64'(sat4));
        end
    endtask

    task automatic cycle(input bit v, input logic [31:0] d, input bit l,
                         input bit ab, input bit ordy);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_last   = l;
        bus.abort     = ab;
        bus.out_ready = ordy;
        @(posedge clk);
        model_edge(v, d, l, ab, ordy);
        #1;
        compare();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, {63'd0, bus.in_ready}, 64'd0);
        check({tag, "_out_valid"}, {63'd0, bus.out_valid}, 64'd0);
        check({tag, "_out_min"}, {32'd0, bus.out_min}, 64'd0);
        check({tag, "_out_max"}, {32'd0, bus.out_max}, 64'd0);
        check({tag, "_out_count"}, {48'd0, bus.out_count}, 64'd0);
        check({tag, "_out_valid4"}, {63'd0, bus4.out_valid}, 64'd0);
    endtask

    function automatic logic [31:0] pick_data();
        logic [31:0] corners[5];
        corners[0] = 32'h7FFF_FFFF;
        corners[1] = 32'h8000_0000;
        corners[2] = 32'h0000_0000;
        corners[3] = 32'hFFFF_FFFF;
        corners[4] = 32'h7FFF_FFFE;
        case ($urandom_range(0, 2))
            0: return corners[$urandom_range(0, 4)];
            1: return 32'($signed($urandom_range(0, 200)) - 100);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        holding       = 1'b0;
        exp_min       = '0;
        exp_max       = '0;
        exp_cnt       = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Packet 5, 10, -3, 7
        cycle(1, 32'd5, 0, 0, 0);
        cycle(1, 32'd10, 0, 0, 0);
        cycle(1, 32'hFFFF_FFFD, 0, 0, 0);
        cycle(1, 32'd7, 1, 0, 0);
        check("t1_min", {32'd0, bus.out_min}, 64'hFFFF_FFFD);
        check("t1_max", {32'd0, bus.out_max}, 64'd10);
        check("t1_count", {48'd0, bus.out_count}, 64'd4);
        cycle(0, 32'd0, 0, 0, 1);

        // Overflow corners
        cycle(1, 32'h7FFF_FFFF, 0, 0, 1);
        cycle(1, 32'h8000_0000, 0, 0, 1);
        cycle(1, 32'h7FFF_FFFE, 1, 0, 1);
        check("t2_min", {32'd0, bus.out_min}, 64'h8000_0000);
        check("t2_max", {32'd0, bus.out_max}, 64'h7FFF_FFFF);
        check("t2_count", {48'd0, bus.out_count}, 64'd3);
        cycle(0, 32'd0, 0, 0, 1);

        // Single beat -15, result held three cycles
        cycle(1, 32'hFFFF_FFF1, 1, 0, 0);
        repeat (3) cycle(1, 32'd77, 0, 0, 0);
        check("t3_min", {32'd0, bus.out_min}, 64'hFFFF_FFF1);
        check("t3_count", {48'd0, bus.out_count}, 64'd1);
        cycle(0, 32'd0, 0, 0, 1);

        // Back-to-back packets with a one-cycle bubble
        cycle(1, 32'd1, 0, 0, 1);
        cycle(1, 32'd2, 1, 0, 1);
        check("t4a_max", {32'd0, bus.out_max}, 64'd2);
        cycle(1, 32'hFFFF_FC18, 0, 0, 1);
        check("t4_bubble", {63'd0, bus.in_ready}, 64'd1);
        cycle(1, 32'hFFFF_FC18, 0, 0, 1);
        cycle(1, 32'hFFFF_FE0C, 1, 0, 1);
        check("t4b_min", {32'd0, bus.out_min}, 64'hFFFF_FC18);
        check("t4b_max", {32'd0, bus.out_max}, 64'hFFFF_FE0C);
        cycle(0, 32'd0, 0, 0, 1);

        // 20 beats of 9: the 4-bit counter saturates
        for (int i = 0; i < 20; i++) cycle(1, 32'd9, (i == 19), 0, 0);
        check("t5_count4", {60'd0, bus4.out_count}, 64'd15);
        check("t5_count16", {48'd0, bus.out_count}, 64'd20);
        check("t5_min4", {32'd0, bus4.out_min}, 64'd9);
        cycle(0, 32'd0, 0, 0, 1);

        // Abort mid-packet, beat in the abort cycle dropped
        cycle(1, 32'd3, 0, 0, 1);
        cycle(1, 32'd4, 0, 0, 1);
        cycle(1, 32'd99, 1, 1, 1);
        cycle(1, 32'd8, 1, 0, 0);
        check("t6_min", {32'd0, bus.out_min}, 64'd8);
        check("t6_max", {32'd0, bus.out_max}, 64'd8);
        check("t6_count", {48'd0, bus.out_count}, 64'd1);

        // Reset pulsed while holding a result
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_values("rst_hold");
        beats.delete();
        holding = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom_range(0, 3) != 0), pick_data(),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 40) == 0),
                  ($urandom_range(0, 2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
